// File: rtl/mult_ctrl.sv
// Sequencing controller for the MULT shift-add multiplier: one start request
// walks the datapath through clear, load and N MSB-first add/shift iterations.
module mult_ctrl #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic bit_in,
    output logic dp_clr,
    output logic ld,
    output logic ldp,
    output logic shb,
    output logic shp,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        ADD,
        SHB,
        SHP,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // The partial-product load follows the multiplier bit the datapath is
    // presenting during ADD; the datapath registers it on the same edge.
    assign ldp = (state == ADD) && bit_in;

    // Moore outputs are registered: each one is set on the transition into
    // the state that owns it, so they line up exactly with the state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            dp_clr <= 1'b0;
            ld     <= 1'b0;
            shb    <= 1'b0;
            shp    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            dp_clr <= 1'b0;
            ld     <= 1'b0;
            shb    <= 1'b0;
            shp    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        dp_clr <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= LOAD;
                    ld    <= 1'b1;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    state <= ADD;
                    busy  <= 1'b1;
                end
                ADD: begin
                    cnt <= cnt + 1'b1;
                    // The last bit gets no trailing shifts.
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= SHB;
                        shb   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SHB: begin
                    state <= SHP;
                    shp   <= 1'b1;
                    busy  <= 1'b1;
                end
                SHP: begin
                    state <= ADD;
                    busy  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl: a behavioural model of the MULT datapath
// feeds bit_in, and expected per-cycle strobes plus the final product are queued.
module tb_mult_ctrl;

    localparam int N = 4;

    logic clk;
    logic clr;
    logic start;
    logic bit_in;
    logic dp_clr, ld, ldp, shb, shp, busy, done;

    mult_ctrl #(.N(N)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .bit_in (bit_in),
        .dp_clr (dp_clr),
        .ld     (ld),
        .ldp    (ldp),
        .shb    (shb),
        .shp    (shp),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected activity for one cycle; vector order {dp_clr,ld,ldp,shb,shp,busy,done}.
    typedef struct {
        int             cyc;
        logic [6:0]     v;
        logic [2*N-1:0] prod;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int done_period = -10;

    logic [N-1:0]   a_op, b_op;
    logic [N-1:0]   a_reg, b_reg;
    logic [2*N-1:0] p_reg;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MULT datapath reacting to the controller's strobes.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
        end else begin
            if (dp_clr) p_reg <= '0;
            if (ld) begin
                a_reg <= a_op;
                b_reg <= b_op;
            end
            if (ldp) p_reg <= p_reg + {{N{1'b0}}, a_reg};
            if (shp) p_reg <= p_reg << 1;
            if (shb) b_reg <= b_reg << 1;
        end
    end

    assign bit_in = b_reg[N-1];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, actual, expected);
        end
    endtask

    function automatic logic [6:0] outs();
        return {dp_clr, ld, ldp, shb, shp, busy, done};
    endfunction

    // Queue the whole operation from the arithmetic rules of the sequence.
    task automatic pushOperation(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int t;
        e.prod = '0;
        e.cyc = k;     e.v = 7'b1000010; q.push_back(e);
        e.cyc = k + 1; e.v = 7'b0100010; q.push_back(e);
        for (int i = 0; i < N; i++) begin
            t = k + 2 + 3 * i;
            e.cyc = t;
            e.v = {2'b00, b[N-1-i], 4'b0010};
            q.push_back(e);
            if (i < N - 1) begin
                e.cyc = t + 1; e.v = 7'b0001010; q.push_back(e);
                e.cyc = t + 2; e.v = 7'b0000110; q.push_back(e);
            end
        end
        e.cyc  = k + 3 * N;
        e.v    = 7'b0000001;
        e.prod = (2*N)'(a) * (2*N)'(b);
        q.push_back(e);
        done_period = k + 3 * N;
    endtask

    // Called just after a falling edge: drives start for the next rising edge.
    task automatic applyStimulus(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
        start = s;
        if (s && !clr && cyc >= done_period + 1) begin
            a_op = a;
            b_op = b;
            pushOperation(cyc + 1, a, b);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [6:0] obs;
        if (!clr) begin
            obs = outs();
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                $display("[TB] FAIL missed_output expected at cycle %0d: got nothing, expected %0h",
                         q[0].cyc, q[0].v);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                checkOutput("strobes", 32'(obs), 32'(e.v));
                if (e.v[0]) checkOutput("product", 32'(p_reg), 32'(e.prod));
            end else if (obs != 7'b0) begin
                checks++;
                $display("[TB] FAIL unexpected_output at cycle %0d: got %0h, expected 0",
                         cyc, obs);
            end
        end
    end

    initial begin
        int waited;
        start = 1'b0;
        a_op  = '0;
        b_op  = '0;
        clr   = 1'b1;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_outputs", 32'(outs()), 32'd0);
        end
        clr   = 1'b0;
        start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checkOutput("idle_quiet", 32'(outs()), 32'd0);
        end

        applyStimulus(1'b1, 4'b1001, 4'b0111);
        repeat (14) applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, 4'b1010, 4'b0000);
        repeat (14) applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, 4'b1111, 4'b1111);
        repeat (14) applyStimulus(1'b0, '0, '0);

        // Start held high across back-to-back operations.
        repeat (30) applyStimulus(1'b1, N'($urandom), N'($urandom));
        repeat (14) applyStimulus(1'b0, '0, '0);

        repeat (400) applyStimulus($urandom_range(0, 3) == 0, N'($urandom), N'($urandom));
        repeat (14) applyStimulus(1'b0, '0, '0);

        // Abort during the second SHB, then run a clean operation.
        applyStimulus(1'b1, 4'b1101, 4'b1011);
        while (cyc < done_period - 3 * N + 6) @(negedge clk);
        clr   = 1'b1;
        start = 1'b1;
        #1;
        checkOutput("async_reset_outputs", 32'(outs()), 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset_hold_outputs", 32'(outs()), 32'd0);
        end
        q.delete();
        done_period = -10;
        clr   = 1'b0;
        start = 1'b0;
        repeat (3) applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, 4'b0110, 4'b1110);

        waited = 0;
        while (q.size() > 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard_drained", 32'(q.size()), 32'd0);
        repeat (3) applyStimulus(1'b0, '0, '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
